load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and size normalisation
// for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RVALID
  } lsu_state_t;

  // Encoding 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables + store lane replication for the request side,
// lane extraction + sign/zero extension for the load-response side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    unique case (1'b1)
      st_size == SZ_BYTE: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      st_size == SZ_HALF: begin
        be    = 4'b0011 << st_off;
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign lbyte = rdata[{ld_off, 3'b000} +: 8];
  assign lhalf = ld_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ldata = rdata;
    unique case (1'b1)
      ld_size == SZ_BYTE:
        ldata = {{24{~ld_unsigned & lbyte[7]}}, lbyte};
      ld_size == SZ_HALF:
        ldata = {{16{~ld_unsigned & lhalf[15]}}, lhalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding LSU, IDLE/REQ/WAIT_RVALID FSM, core
// req_* in, mem_* req/gnt/rvalid out. Macro LSU_MISALIGN_TRAP_EN traps
// misaligned accesses; otherwise they are truncated to natural alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              req_ready_o,
  output logic              stall_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              misaligned_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  lsu_state_t        state;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [ADDR_W-3:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic [1:0]  sz;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ldata;
  logic        trap;
  logic        issue;
  logic        done;

  assign sz = norm_size(req_size_i);

  // Lane offset already truncated to the natural alignment of the size.
  always_comb begin
    unique case (1'b1)
      sz == SZ_BYTE: off = req_addr_i[1:0];
      sz == SZ_HALF: off = {req_addr_i[1], 1'b0};
      default:       off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (sz == SZ_HALF && req_addr_i[0]) ||
                (sz == SZ_WORD && req_addr_i[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  lsu_align u_align (
    .st_size     (sz),
    .st_off      (off),
    .st_data     (req_wdata_i),
    .be          (be),
    .wdata       (wdata),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .rdata       (mem_rdata_i),
    .ldata       (ldata)
  );

  assign issue = rst_n && state == IDLE && req_valid_i && !trap;
  assign done  = state == WAIT_RVALID && mem_rvalid_i;

  // First request cycle is driven straight from the core; later cycles
  // replay the latched copy so the bus stays stable until grant.
  assign mem_req_o   = issue || state == REQ;
  assign mem_we_o    = issue ? req_we_i : we_q;
  assign mem_be_o    = issue ? be : be_q;
  assign mem_addr_o  = issue ? {req_addr_i[ADDR_W-1:2], 2'b00}
                             : {addr_q, 2'b00};
  assign mem_wdata_o = issue ? wdata : wdata_q;

  assign misaligned_o = rst_n && state == IDLE && req_valid_i && trap;
  assign resp_valid_o = done && !we_q;
  assign resp_rdata_o = resp_valid_o ? ldata : rdata_q;
  assign req_ready_o  = done || misaligned_o;
  assign stall_o      = req_valid_i && !req_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      off_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            size_q  <= sz;
            off_q   <= off;
            addr_q  <= req_addr_i[ADDR_W-1:2];
            be_q    <= be;
            wdata_q <= wdata;
            state   <= mem_gnt_i ? WAIT_RVALID : REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) state <= WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (mem_rvalid_i) begin
            state <= IDLE;
            if (!we_q) rdata_q <= ldata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for
// grant stalls, misaligned handling and reset abandoning an access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        req_ready_o;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        misaligned_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_ready_o    (req_ready_o),
    .stall_o        (stall_o),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .misaligned_o   (misaligned_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gw;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rexp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size,
      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
      input logic [31:0] rdata, input int gw, input logic [3:0] be,
      input logic [31:0] maddr, input logic [31:0] mwdata,
      input logic [31:0] rexp);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.gw = gw; v.be = be;
    v.maddr = maddr; v.mwdata = mwdata; v.rexp = rexp;
    return v;
  endfunction

  task automatic do_access(input vec_t v, input int idx);
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  b0;
    string t;
    t = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = v.we; req_size_i = v.size;
    req_unsigned_i = v.uns; req_addr_i = v.addr; req_wdata_i = v.wdata;
    mem_gnt_i = (v.gw == 0); mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk({t, " req"}, {31'd0, mem_req_o}, 32'd1);
    chk({t, " we"}, {31'd0, mem_we_o}, {31'd0, v.we});
    chk({t, " be"}, {28'd0, mem_be_o}, {28'd0, v.be});
    chk({t, " addr"}, mem_addr_o, v.maddr);
    if (v.we) chk({t, " wdata"}, mem_wdata_o, v.mwdata);
    chk({t, " stall"}, {31'd0, stall_o}, 32'd1);
    chk({t, " mis"}, {31'd0, misaligned_o}, 32'd0);
    a0 = mem_addr_o; w0 = mem_wdata_o; b0 = mem_be_o;
    for (int i = 0; i < v.gw; i++) begin
      @(posedge clk); #1;
      mem_gnt_i = (i == v.gw - 1);
      req_addr_i = ~v.addr; req_wdata_i = ~v.wdata;
      @(negedge clk);
      chk({t, " hold req"}, {31'd0, mem_req_o}, 32'd1);
      chk({t, " hold addr"}, mem_addr_o, a0);
      chk({t, " hold wdata"}, mem_wdata_o, w0);
      chk({t, " hold be"}, {28'd0, mem_be_o}, {28'd0, b0});
      chk({t, " hold stall"}, {31'd0, stall_o}, 32'd1);
    end
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = v.rdata;
    @(negedge clk);
    chk({t, " req off"}, {31'd0, mem_req_o}, 32'd0);
    chk({t, " ready"}, {31'd0, req_ready_o}, 32'd1);
    chk({t, " stall0"}, {31'd0, stall_o}, 32'd0);
    chk({t, " rvld"}, {31'd0, resp_valid_o}, {31'd0, !v.we});
    if (!v.we) chk({t, " rdata"}, resp_rdata_o, v.rexp);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk);
    chk({t, " rvld end"}, {31'd0, resp_valid_o}, 32'd0);
    chk({t, " ready end"}, {31'd0, req_ready_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            we size  u  addr   wdata         rdata        gw be
    tv[0]  = mk(0, 2'b10, 0, 32'h0, 32'h0, 32'hDEADBEEF, 0, 4'b1111,
                32'h0, 32'h0, 32'hDEADBEEF);
    tv[1]  = mk(0, 2'b00, 0, 32'h3, 32'h0, 32'h80112233, 0, 4'b1000,
                32'h0, 32'h0, 32'hFFFFFF80);
    tv[2]  = mk(0, 2'b00, 1, 32'h3, 32'h0, 32'h80112233, 0, 4'b1000,
                32'h0, 32'h0, 32'h00000080);
    tv[3]  = mk(0, 2'b01, 1, 32'h2, 32'h0, 32'h80112233, 0, 4'b1100,
                32'h0, 32'h0, 32'h00008011);
    tv[4]  = mk(0, 2'b01, 0, 32'h2, 32'h0, 32'h80112233, 1, 4'b1100,
                32'h0, 32'h0, 32'hFFFF8011);
    tv[5]  = mk(0, 2'b00, 0, 32'h1, 32'h0, 32'h80112233, 0, 4'b0010,
                32'h0, 32'h0, 32'h00000022);
    tv[6]  = mk(1, 2'b00, 0, 32'h1, 32'h000000A5, 32'h0, 0, 4'b0010,
                32'h0, 32'hA5A5A5A5, 32'h0);
    tv[7]  = mk(1, 2'b01, 0, 32'h2, 32'h1234BEEF, 32'h0, 0, 4'b1100,
                32'h0, 32'hBEEFBEEF, 32'h0);
    tv[8]  = mk(1, 2'b10, 0, 32'h10, 32'h12345678, 32'h0, 3, 4'b1111,
                32'h10, 32'h12345678, 32'h0);
    tv[9]  = mk(0, 2'b11, 0, 32'h8, 32'h0, 32'hCAFEF00D, 1, 4'b1111,
                32'h8, 32'h0, 32'hCAFEF00D);
    tv[10] = mk(0, 2'b01, 1, 32'h20, 32'h0, 32'h1234ABCD, 0, 4'b0011,
                32'h20, 32'h0, 32'h0000ABCD);
    tv[11] = mk(0, 2'b01, 0, 32'h20, 32'h0, 32'h1234ABCD, 2, 4'b0011,
                32'h20, 32'h0, 32'hFFFFABCD);

    #12;
    chk("rst req", {31'd0, mem_req_o}, 32'd0);
    chk("rst we", {31'd0, mem_we_o}, 32'd0);
    chk("rst be", {28'd0, mem_be_o}, 32'd0);
    chk("rst addr", mem_addr_o, 32'd0);
    chk("rst wdata", mem_wdata_o, 32'd0);
    chk("rst rdata", resp_rdata_o, 32'd0);
    chk("rst rvld", {31'd0, resp_valid_o}, 32'd0);
    chk("rst mis", {31'd0, misaligned_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_access(tv[i], i);

    // Misaligned word load at 0x6.
`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10;
    req_unsigned_i = 1'b0; req_addr_i = 32'h6; mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("mis pulse", {31'd0, misaligned_o}, 32'd1);
    chk("mis noreq", {31'd0, mem_req_o}, 32'd0);
    chk("mis ready", {31'd0, req_ready_o}, 32'd1);
    chk("mis stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0; mem_gnt_i = 1'b0;
    @(negedge clk);
    chk("mis end", {31'd0, misaligned_o}, 32'd0);
    chk("mis idle req", {31'd0, mem_req_o}, 32'd0);
`else
    do_access(mk(0, 2'b10, 0, 32'h6, 32'h0, 32'h11223344, 0, 4'b1111,
                 32'h4, 32'h0, 32'h11223344), 100);
    do_access(mk(0, 2'b01, 1, 32'h3, 32'h0, 32'h80112233, 0, 4'b1100,
                 32'h0, 32'h0, 32'h00008011), 101);
`endif

    // Reset while waiting for rvalid abandons the load.
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10;
    req_addr_i = 32'h40; mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; mem_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort req", {31'd0, mem_req_o}, 32'd0);
    chk("abort addr", mem_addr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    @(negedge clk);
    chk("abort rvld", {31'd0, resp_valid_o}, 32'd0);
    chk("abort ready", {31'd0, req_ready_o}, 32'd0);
    chk("abort rdata", resp_rdata_o, 32'd0);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    do_access(tv[0], 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
